seg_display_scanner: RTL and testbench

//  Multiplexed 7-segment display driver. Sits directly downstream of the clock divider and consumes its clk_10KHz output.
//  clk_10KHz is treated as data, not as a clock: it is synchronised into clock1M and edge-detected to form a scan tick.

---
 rtl/seg_pkg.sv | 38 +++
 rtl/tick_sync.sv | 29 ++
 rtl/seg_display_scanner.sv | 148 ++++++++++++++
 tb/tb_seg_display_scanner.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types, constants and the hex-to-segment encoder for the 7-segment scanner.
package seg_pkg;

   // Scanner FSM states: BLANK keeps every anode off, SHOW drives the current digit.
   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } scan_state_t;

   // Segment pattern with every segment dark (active-low).
   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      logic [6:0] seg;
      case (nibble)
         4'h0:    seg = 7'b1000000;
         4'h1:    seg = 7'b1111001;
         4'h2:    seg = 7'b0100100;
         4'h3:    seg = 7'b0110000;
         4'h4:    seg = 7'b0011001;
         4'h5:    seg = 7'b0010010;
         4'h6:    seg = 7'b0000010;
         4'h7:    seg = 7'b1111000;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0010000;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b0000011;
         4'hC:    seg = 7'b1000110;
         4'hD:    seg = 7'b0100001;
         4'hE:    seg = 7'b0000110;
         4'hF:    seg = 7'b0001110;
         default: seg = SEG_OFF;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/tick_sync.sv
// Brings the asynchronous scan-rate square wave into the clock1M domain and turns
// each rising edge into a single-cycle tick.
module tick_sync (
   input  logic clock1M,
   input  logic reset,
   input  logic async_in,
   output logic tick_out
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;

   // Two-flop synchroniser followed by a one-cycle history flop for edge detection.
   always_ff @(posedge clock1M or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= async_in;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign tick_out = r_sync2 & ~r_prev;

endmodule

// File: rtl/seg_display_scanner.sv
// Multiplexed 7-segment display driver: scans NUM_DIGITS digits, one per scan tick,
// with an all-dark gap between digits and frame-aligned double-buffered data.
module seg_display_scanner
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 8,
   parameter int BLANK_CYCLES = 4
) (
   input  logic                    clock1M,
   input  logic                    reset,
   input  logic                    clk_10KHz,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   en_in,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic [6:0]              seg_n,
   output logic                    dp_n,
   output logic                    frame_start
);

   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int CNT_W = 7;
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   // Reject configurations the index and blank counter widths cannot represent.
   generate
      if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_badDigits
         $error("seg_display_scanner: NUM_DIGITS must be in 2..8");
      end
      if (BLANK_CYCLES < 1 || BLANK_CYCLES > 90) begin : g_badBlank
         $error("seg_display_scanner: BLANK_CYCLES must be in 1..90");
      end
   endgenerate

   scan_state_t               r_state;
   logic [IDX_W-1:0]          r_idx;
   logic [CNT_W-1:0]          r_blankCnt;
   logic [4*NUM_DIGITS-1:0]   r_shadowData;
   logic [NUM_DIGITS-1:0]     r_shadowDp;
   logic [NUM_DIGITS-1:0]     r_shadowEn;
   logic [4*NUM_DIGITS-1:0]   r_stageData;
   logic [NUM_DIGITS-1:0]     r_stageDp;
   logic [NUM_DIGITS-1:0]     r_stageEn;
   logic                      r_pending;
   logic [NUM_DIGITS-1:0]     r_anN;
   logic [6:0]                r_segN;
   logic                      r_dpN;
   logic                      r_frameStart;

   logic                      w_tick;
   logic                      w_wrap;
   logic [3:0]                w_nibble;
   logic [NUM_DIGITS-1:0]     w_anShow;

   tick_sync u_tickSync (
      .clock1M  (clock1M),
      .reset    (reset),
      .async_in (clk_10KHz),
      .tick_out (w_tick)
   );

   // The frame boundary is the tick that moves the scan from the last digit back to digit 0.
   assign w_wrap   = (r_state == SHOW) && w_tick && (r_idx == LAST_IDX);
   assign w_nibble = r_shadowData[{r_idx, 2'b00} +: 4];

   // Anode pattern for the digit being shown; a disabled slot leaves every anode off.
   always_comb begin
      w_anShow = '1;
      if (r_shadowEn[r_idx]) begin
         w_anShow[r_idx] = 1'b0;
      end
   end

   // Staging/shadow double buffer: new data only reaches the display at a frame boundary,
   // and a load landing on that boundary goes straight to the shadow copy.
   always_ff @(posedge clock1M or negedge reset) begin
      if (!reset) begin
         r_shadowData <= '0;
         r_shadowDp   <= '0;
         r_shadowEn   <= '0;
         r_stageData  <= '0;
         r_stageDp    <= '0;
         r_stageEn    <= '0;
         r_pending    <= 1'b0;
      end else if (w_wrap) begin
         if (load) begin
            r_shadowData <= data_in;
            r_shadowDp   <= dp_in;
            r_shadowEn   <= en_in;
         end else if (r_pending) begin
            r_shadowData <= r_stageData;
            r_shadowDp   <= r_stageDp;
            r_shadowEn   <= r_stageEn;
         end
         r_pending <= 1'b0;
      end else if (load) begin
         r_stageData <= data_in;
         r_stageDp   <= dp_in;
         r_stageEn   <= en_in;
         r_pending   <= 1'b1;
      end
   end

   // Scan FSM: show a digit until the next tick, then hold all anodes off for BLANK_CYCLES;
   // outputs are registered from the state held before each edge.
   always_ff @(posedge clock1M or negedge reset) begin
      if (!reset) begin
         r_state      <= BLANK;
         r_idx        <= '0;
         r_blankCnt   <= '0;
         r_anN        <= '1;
         r_segN       <= SEG_OFF;
         r_dpN        <= 1'b1;
         r_frameStart <= 1'b0;
      end else begin
         r_frameStart <= w_wrap;
         case (r_state)
            SHOW: begin
               r_anN  <= w_anShow;
               r_segN <= hex_to_seg(w_nibble);
               r_dpN  <= ~r_shadowDp[r_idx];
               if (w_tick) begin
                  r_idx      <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
                  r_state    <= BLANK;
                  r_blankCnt <= '0;
               end
            end
            default: begin
               r_anN      <= '1;
               r_segN     <= SEG_OFF;
               r_dpN      <= 1'b1;
               r_blankCnt <= r_blankCnt + 1'b1;
               if (r_blankCnt == BLANK_LAST) begin
                  r_state <= SHOW;
               end
            end
         endcase
      end
   end

   assign an_n        = r_anN;
   assign seg_n       = r_segN;
   assign dp_n        = r_dpN;
   assign frame_start = r_frameStart;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner: a per-cycle behavioural scoreboard plus
// table-driven frame checks and hand-written multi-cycle sequences.
module tb_seg_display_scanner;

   localparam int ND = 8;
   localparam int BC = 4;

   logic          clock1M = 1'b0;
   logic          reset;
   logic          clk_10KHz = 1'b0;
   logic          load;
   logic [31:0]   data_in;
   logic [7:0]    dp_in;
   logic [7:0]    en_in;
   logic [7:0]    an_n;
   logic [6:0]    seg_n;
   logic          dp_n;
   logic          frame_start;

   int errors = 0;
   int checks = 0;

   seg_display_scanner #(.NUM_DIGITS(ND), .BLANK_CYCLES(BC)) dut (
      .clock1M     (clock1M),
      .reset       (reset),
      .clk_10KHz   (clk_10KHz),
      .load        (load),
      .data_in     (data_in),
      .dp_in       (dp_in),
      .en_in       (en_in),
      .an_n        (an_n),
      .seg_n       (seg_n),
      .dp_n        (dp_n),
      .frame_start (frame_start)
   );

   // 1 MHz system clock stand-in.
   always #5 clock1M = ~clock1M;

   // Scan-rate square wave, changed on falling edges; randomScan varies its duty and period.
   int hiCycles = 10;
   int loCycles = 10;
   bit scanRun = 1'b0;
   bit randomScan = 1'b0;
   always begin
      @(negedge clock1M);
      if (scanRun) begin
         clk_10KHz = 1'b1;
         repeat (hiCycles) @(negedge clock1M);
         clk_10KHz = 1'b0;
         repeat (loCycles) @(negedge clock1M);
         if (randomScan) begin
            hiCycles = $urandom_range(1, 30);
            loCycles = $urandom_range(1, 30);
            if ($urandom_range(0, 9) == 0) hiCycles = $urandom_range(100, 400);
         end
      end
   end

   // Reference encoding table, digit value -> active-low {g,f,e,d,c,b,a}.
   logic [6:0] segTable [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   int          mDigit;
   int          mBlankLeft;
   bit          mLit;
   bit [2:0]    mHist;
   logic [31:0] mShadowData, mStageData;
   logic [7:0]  mShadowDp, mShadowEn, mStageDp, mStageEn;
   bit          mPending;
   logic [7:0]  eAn;
   logic [6:0]  eSeg;
   logic        eDp, eFs;
   wire         mTick = mHist[1] & ~mHist[2];
   wire         mWrap = mLit & mTick & (mDigit == ND - 1);

   // Behavioural model: a lit digit or a countdown of dark cycles, scan input seen two cycles late.
   always @(posedge clock1M or negedge reset) begin
      if (!reset) begin
         mDigit <= 0; mBlankLeft <= BC; mLit <= 1'b0; mHist <= '0;
         mShadowData <= '0; mShadowDp <= '0; mShadowEn <= '0;
         mStageData <= '0; mStageDp <= '0; mStageEn <= '0; mPending <= 1'b0;
         eAn <= 8'hFF; eSeg <= 7'h7F; eDp <= 1'b1; eFs <= 1'b0;
      end else begin
         mHist <= {mHist[1:0], clk_10KHz};
         eFs <= mWrap;
         if (mLit) begin
            eAn  <= mShadowEn[mDigit] ? ~(8'b1 << mDigit) : 8'hFF;
            eSeg <= segTable[mShadowData[4*mDigit +: 4]];
            eDp  <= !mShadowDp[mDigit];
            if (mTick) begin
               mDigit <= (mDigit + 1) % ND;
               mLit <= 1'b0;
               mBlankLeft <= BC;
            end
         end else begin
            eAn <= 8'hFF; eSeg <= 7'h7F; eDp <= 1'b1;
            mBlankLeft <= mBlankLeft - 1;
            if (mBlankLeft == 1) mLit <= 1'b1;
         end
         if (mWrap) begin
            if (load) begin
               mShadowData <= data_in; mShadowDp <= dp_in; mShadowEn <= en_in;
            end else if (mPending) begin
               mShadowData <= mStageData; mShadowDp <= mStageDp; mShadowEn <= mStageEn;
            end
            mPending <= 1'b0;
         end else if (load) begin
            mStageData <= data_in; mStageDp <= dp_in; mStageEn <= en_in;
            mPending <= 1'b1;
         end
      end
   end

   // Compares one observed value against its required value and records the outcome.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every cycle the outputs must match the scoreboard and at most one anode may be low.
   bit checkEn = 1'b0;
   always @(negedge clock1M) begin
      if (checkEn) begin
         checkOutput("model an_n", an_n, eAn);
         checkOutput("model seg_n", seg_n, eSeg);
         checkOutput("model dp_n", dp_n, eDp);
         checkOutput("model frame_start", frame_start, eFs);
         checkOutput("single anode", ($countones(~an_n) <= 1), 1);
      end
   end

   // One-cycle load strobe with the given display contents.
   task automatic applyStimulus(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
      @(negedge clock1M);
      data_in = d; dp_in = dp; en_in = en; load = 1'b1;
      @(negedge clock1M);
      load = 1'b0;
   endtask

   task automatic waitFrame();
      bit seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clock1M);
         if (frame_start) seen = 1'b1;
      end
      if (!seen) checkOutput("frame_start timeout", 0, 1);
   endtask

   task automatic waitAnode(input logic [7:0] v);
      bit seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clock1M);
         if (an_n == v) seen = 1'b1;
      end
      if (!seen) checkOutput("anode wait timeout", {24'h0, an_n}, {24'h0, v});
   endtask

   typedef struct {
      logic [31:0] data;
      logic [7:0]  dp;
      logic [7:0]  en;
      logic [6:0]  expSeg;
      logic [7:0]  expAn;
      logic        expDp;
   } vec_t;

   vec_t vecs [18];
   int   cnt, cntB;

   initial begin
      reset = 1'b0; load = 1'b0; data_in = '0; dp_in = '0; en_in = '0;
      for (int i = 0; i < 16; i++) begin
         vecs[i].data   = {8{4'(i)}};
         vecs[i].dp     = {7'b0, 1'(i)};
         vecs[i].en     = 8'h01;
         vecs[i].expSeg = segTable[i];
         vecs[i].expAn  = 8'hFE;
         vecs[i].expDp  = !1'(i);
      end
      vecs[16] = '{32'h00000005, 8'h01, 8'h00, 7'b0010010, 8'hFF, 1'b0};
      vecs[17] = '{32'h12345678, 8'h01, 8'hFF, 7'b0000000, 8'hFE, 1'b0};

      // Reset held while the scan input toggles: everything dark.
      scanRun = 1'b1;
      @(negedge clock1M);
      checkEn = 1'b1;
      repeat (40) @(negedge clock1M);
      checkOutput("reset an_n", an_n, 8'hFF);
      checkOutput("reset seg_n", seg_n, 7'h7F);
      checkOutput("reset dp_n", dp_n, 1);
      checkOutput("reset frame_start", frame_start, 0);
      reset = 1'b1;

      // Each table entry becomes visible on digit 0 BLANK_CYCLES+1 cycles after the frame pulse.
      for (int i = 0; i < 18; i++) begin
         applyStimulus(vecs[i].data, vecs[i].dp, vecs[i].en);
         waitFrame();
         repeat (BC + 1) @(negedge clock1M);
         checkOutput($sformatf("vec%0d seg_n", i), seg_n, vecs[i].expSeg);
         checkOutput($sformatf("vec%0d an_n", i), an_n, vecs[i].expAn);
         checkOutput($sformatf("vec%0d dp_n", i), dp_n, vecs[i].expDp);
      end

      // Last digit of 12345678 is '1'.
      waitAnode(8'h7F);
      checkOutput("digit7 seg_n", seg_n, 7'b1111001);
      checkOutput("digit7 dp_n", dp_n, 1);

      // Dark gap between digits lasts exactly BLANK_CYCLES.
      for (int k = 0; k < 3; k++) begin
         waitAnode(8'hBF);
         cnt = 0;
         for (int i = 0; i < 200 && an_n != 8'hFF; i++) @(negedge clock1M);
         for (int i = 0; i < 50 && an_n == 8'hFF; i++) begin
            cnt++;
            @(negedge clock1M);
         end
         checkOutput("blank gap length", cnt, BC);
      end

      // A load mid-frame must not tear the current frame.
      waitAnode(8'hF7);
      applyStimulus(32'h9ABCDEF0, 8'h00, 8'hFF);
      waitAnode(8'h7F);
      checkOutput("no tear digit7", seg_n, 7'b1111001);
      waitFrame();
      repeat (BC + 1) @(negedge clock1M);
      checkOutput("new frame digit0", seg_n, 7'b1000000);

      // A disabled slot stays dark for its whole period.
      applyStimulus(32'h76543210, 8'h00, 8'hF7);
      waitFrame();
      waitFrame();
      cnt = 0; cntB = 0;
      for (int i = 0; i < 170; i++) begin
         @(negedge clock1M);
         if (an_n == 8'hF7) cnt++;
         if (an_n == 8'hFB) cntB++;
      end
      checkOutput("disabled slot lit", cnt, 0);
      checkOutput("neighbour slot lit", (cntB > 0), 1);

      // Asynchronous reset mid-digit: outputs drop before any clock edge.
      applyStimulus(32'h76543210, 8'hFF, 8'hFF);
      waitFrame();
      waitAnode(8'hDF);
      @(posedge clock1M);
      #2 reset = 1'b0;
      #1;
      checkOutput("async reset an_n", an_n, 8'hFF);
      checkOutput("async reset seg_n", seg_n, 7'h7F);
      checkOutput("async reset dp_n", dp_n, 1);
      repeat (3) @(negedge clock1M);
      reset = 1'b1;
      cnt = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clock1M);
         if (an_n != 8'hFF) cnt++;
      end
      checkOutput("cleared shadow stays dark", cnt, 0);

      // Random scan timing and frequent random loads against the scoreboard.
      randomScan = 1'b1;
      for (int i = 0; i < 25000; i++) begin
         @(negedge clock1M);
         if ($urandom_range(0, 3) == 0) begin
            load = 1'b1;
            data_in = $urandom;
            dp_in = 8'($urandom);
            en_in = 8'($urandom);
         end else begin
            load = 1'b0;
         end
      end
      load = 1'b0;
      repeat (2) @(negedge clock1M);
      checkEn = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
